// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: opcodes, access-size codes, FSM state
// encoding and the rv32i immediate decoders.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

package lsu_pkg;

  typedef logic [31:0] rv32i_inst_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3[1:0] access size; any 1x code is a word access
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  function automatic logic [`RV_XLEN-1:0] i_imm_decode(input logic [11:0] imm_i);
    return {{20{imm_i[11]}}, imm_i};
  endfunction

  function automatic logic [`RV_XLEN-1:0] s_imm_decode(input logic [6:0] imm_hi,
                                                       input logic [4:0] imm_lo);
    return {{20{imm_hi[6]}}, imm_hi, imm_lo};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: selects the addressed byte/half of the read word and
// sign- or zero-extends it (funct3[2] = 1 selects zero-extension).
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [`RV_XLEN-1:0] rdata,
  input  logic [1:0]          addr_lo,
  input  logic [2:0]          funct3,
  output logic [`RV_XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3[1:0])
      SZ_BYTE: result = {{24{~funct3[2] & byte_s[7]}}, byte_s};
      SZ_HALF: result = {{16{~funct3[2] & half_s[15]}}, half_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/exu_lsu.sv
// rv32i load/store unit: one outstanding transaction on a valid/ready data bus.
// With RV_LSU_MISALIGN_EXC_EN defined, misaligned half/word accesses fault without a bus cycle.
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

module exu_lsu
  import lsu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [31:0]         req_inst,
  input  logic [`RV_XLEN-1:0] req_rs1,
  input  logic [`RV_XLEN-1:0] req_rs2,
  output logic                mem_req_vld,
  input  logic                mem_req_rdy,
  output logic [`RV_XLEN-1:0] mem_req_addr,
  output logic                mem_req_we,
  output logic [3:0]          mem_req_be,
  output logic [`RV_XLEN-1:0] mem_req_wdata,
  input  logic                mem_rsp_vld,
  input  logic [`RV_XLEN-1:0] mem_rsp_rdata,
  output logic                done_vld,
  output logic                done_is_load,
  output logic [4:0]          done_rd,
  output logic [`RV_XLEN-1:0] done_data,
  output logic                done_misalign
);

  lsu_state_e          state_q, state_d;
  logic [`RV_XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, done_data_q, done_data_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d, done_rd_q, done_rd_d;
  logic [3:0]          be_q, be_d;
  logic                is_load_q, is_load_d, we_q, we_d, done_is_load_q, done_is_load_d;

  rv32i_inst_t         inst_s;
  logic [`RV_XLEN-1:0] eff_addr_s, req_wdata_s, load_val_s;
  logic [3:0]          req_be_s;
  logic                req_is_load_s, req_is_store_s, req_fire_s;
  logic                unused_rs1_field_s;

  assign inst_s             = req_inst;
  assign req_is_load_s      = (inst_s[6:0] == OPC_LOAD);
  assign req_is_store_s     = (inst_s[6:0] == OPC_STORE);
  assign eff_addr_s         = req_rs1 + (req_is_store_s ? s_imm_decode(inst_s[31:25], inst_s[11:7])
                                                        : i_imm_decode(inst_s[31:20]));
  assign req_fire_s         = req_vld & req_rdy;
  assign unused_rs1_field_s = ^inst_s[19:15];

  // Store lane steering; half accesses only look at addr[1], words at no low bits
  always_comb begin
    req_be_s    = 4'b1111;
    req_wdata_s = req_rs2;
    case (inst_s[13:12])
      SZ_BYTE: begin
        req_be_s    = 4'b0001 << eff_addr_s[1:0];
        req_wdata_s = {4{req_rs2[7:0]}};
      end
      SZ_HALF: begin
        req_be_s    = 4'b0011 << {eff_addr_s[1], 1'b0};
        req_wdata_s = {2{req_rs2[15:0]}};
      end
      default: begin
        req_be_s    = 4'b1111;
        req_wdata_s = req_rs2;
      end
    endcase
  end

`ifdef RV_LSU_MISALIGN_EXC_EN
  logic done_misalign_q, done_misalign_d, req_misalign_s;

  always_comb begin
    case (inst_s[13:12])
      SZ_BYTE: req_misalign_s = 1'b0;
      SZ_HALF: req_misalign_s = eff_addr_s[0];
      default: req_misalign_s = |eff_addr_s[1:0];
    endcase
  end

  assign done_misalign = done_misalign_q;
`else
  assign done_misalign = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata   (mem_rsp_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (load_val_s)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    is_load_d      = is_load_q;
    we_d           = we_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    done_data_d    = done_data_q;
    done_rd_d      = done_rd_q;
    done_is_load_d = done_is_load_q;
`ifdef RV_LSU_MISALIGN_EXC_EN
    done_misalign_d = done_misalign_q;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (req_fire_s) begin
          addr_d    = eff_addr_s;
          funct3_d  = inst_s[14:12];
          rd_d      = inst_s[11:7];
          is_load_d = req_is_load_s;
          we_d      = req_is_store_s;
          be_d      = req_be_s;
          wdata_d   = req_wdata_s;
          state_d   = LSU_REQ;
`ifdef RV_LSU_MISALIGN_EXC_EN
          // Faulting access never reaches the bus; report the effective address
          if (req_misalign_s) begin
            done_data_d     = eff_addr_s;
            done_rd_d       = req_is_load_s ? inst_s[11:7] : 5'd0;
            done_is_load_d  = req_is_load_s;
            done_misalign_d = 1'b1;
            state_d         = LSU_DONE;
          end
`endif
        end
      end
      LSU_REQ: begin
        if (mem_req_rdy) state_d = LSU_RSP;
      end
      LSU_RSP: begin
        if (mem_rsp_vld) begin
          done_data_d    = is_load_q ? load_val_s : {`RV_XLEN{1'b0}};
          done_rd_d      = is_load_q ? rd_q : 5'd0;
          done_is_load_d = is_load_q;
`ifdef RV_LSU_MISALIGN_EXC_EN
          done_misalign_d = 1'b0;
`endif
          state_d        = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LSU_IDLE;
      addr_q         <= {`RV_XLEN{1'b0}};
      funct3_q       <= 3'd0;
      rd_q           <= 5'd0;
      is_load_q      <= 1'b0;
      we_q           <= 1'b0;
      be_q           <= 4'd0;
      wdata_q        <= {`RV_XLEN{1'b0}};
      done_data_q    <= {`RV_XLEN{1'b0}};
      done_rd_q      <= 5'd0;
      done_is_load_q <= 1'b0;
`ifdef RV_LSU_MISALIGN_EXC_EN
      done_misalign_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      funct3_q       <= funct3_d;
      rd_q           <= rd_d;
      is_load_q      <= is_load_d;
      we_q           <= we_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      done_data_q    <= done_data_d;
      done_rd_q      <= done_rd_d;
      done_is_load_q <= done_is_load_d;
`ifdef RV_LSU_MISALIGN_EXC_EN
      done_misalign_q <= done_misalign_d;
`endif
    end
  end

  assign req_rdy       = (state_q == LSU_IDLE) & ~rst;
  assign mem_req_vld   = (state_q == LSU_REQ);
  assign mem_req_addr  = {addr_q[`RV_XLEN-1:2], 2'b00};
  assign mem_req_we    = we_q;
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;
  assign done_vld      = (state_q == LSU_DONE);
  assign done_is_load  = done_is_load_q;
  assign done_rd       = done_rd_q;
  assign done_data     = done_data_q;

endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu: directed and randomized load/store transactions compared
// against a transaction-level model of address, lanes, extension and latency.
`timescale 1ns/1ps
module tb_exu_lsu;

  logic        clk = 1'b0, rst = 1'b1, req_vld = 1'b0, req_rdy;
  logic [31:0] req_inst = 32'd0, req_rs1 = 32'd0, req_rs2 = 32'd0;
  logic        mem_req_vld, mem_req_rdy = 1'b0, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_vld = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'd0;
  logic        done_vld, done_is_load, done_misalign;
  logic [4:0]  done_rd;
  logic [31:0] done_data;

  int checks = 0, errors = 0;

`ifdef RV_LSU_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  exu_lsu dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_inst(req_inst),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdata(mem_rsp_rdata),
    .done_vld(done_vld), .done_is_load(done_is_load), .done_rd(done_rd),
    .done_data(done_data), .done_misalign(done_misalign)
  );

  // expected transaction
  int          e_done_cyc;
  bit          e_bus, e_we, e_is_load, e_mis;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  // observed transaction
  int          o_req_cnt, o_done_cyc;
  bit          o_stable, o_rdy_low, o_after_vld, o_after_rdy, o_timeout;
  logic [31:0] o_addr, o_wdata, o_data;
  logic [3:0]  o_be;
  logic        o_we, o_is_load, o_mis;
  logic [4:0]  o_rd;

  function automatic logic [31:0] mk_load(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [11:0] imm);
    return {imm, 5'd3, f3, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_store(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd4, 5'd3, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic model(input logic [31:0] inst, rs1, rs2, rdata, input int req_wait, rsp_wait);
    logic [31:0] imm, ea, mask, v;
    int size, off;
    e_is_load = (inst[6:0] == 7'b0000011);
    imm  = e_is_load ? {{20{inst[31]}}, inst[31:20]} : {{20{inst[31]}}, inst[31:25], inst[11:7]};
    ea   = rs1 + imm;
    size = (inst[13:12] == 2'b00) ? 1 : (inst[13:12] == 2'b01) ? 2 : 4;
    off  = (size == 4) ? 0 : (size == 2) ? (ea[1] ? 2 : 0) : int'(ea[1:0]);
    e_mis   = MIS_EN && ((size == 2 && ea[0]) || (size == 4 && ea[1:0] != 2'b00));
    e_bus   = !e_mis;
    e_addr  = ea & 32'hFFFF_FFFC;
    e_we    = !e_is_load;
    e_be    = 4'((1 << size) - 1) << off;
    e_wdata = (size == 1) ? {4{rs2[7:0]}} : (size == 2) ? {2{rs2[15:0]}} : rs2;
    e_rd    = e_is_load ? inst[11:7] : 5'd0;
    mask    = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    v       = (rdata >> (8 * off)) & mask;
    if (size < 4 && !inst[14] && v[8 * size - 1]) v = v | ~mask;
    e_data     = e_mis ? ea : (e_is_load ? v : 32'h0);
    e_done_cyc = e_mis ? 1 : 3 + req_wait + rsp_wait;
  endtask

  // Issues one instruction, plays the memory, records what the DUT did.
  // Entered and left at a falling edge; cycle 0 is the accept cycle.
  task automatic do_txn(input logic [31:0] inst, rs1, rs2, rdata,
                        input int req_wait, rsp_wait, input bit noise);
    int rw, sw;
    bit in_rsp, hs;
    o_req_cnt = 0; o_done_cyc = -1; o_stable = 1; o_rdy_low = 1;
    o_after_vld = 1; o_after_rdy = 0; o_timeout = 0;
    o_addr = 32'd0; o_wdata = 32'd0; o_be = 4'd0; o_we = 1'b0;
    o_data = 32'd0; o_is_load = 1'b0; o_mis = 1'b0; o_rd = 5'd0;
    for (int k = 0; k < 20 && !req_rdy; k++) @(negedge clk);
    if (!req_rdy) o_timeout = 1;
    req_vld = 1'b1; req_inst = inst; req_rs1 = rs1; req_rs2 = rs2;
    rw = req_wait; sw = rsp_wait; in_rsp = 0;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      req_vld = 1'b0; req_inst = $urandom(); req_rs1 = $urandom(); req_rs2 = $urandom();
      mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_rdata = $urandom(); hs = 0;
      if (o_done_cyc >= 0) begin
        o_after_vld = done_vld; o_after_rdy = req_rdy;
        break;
      end
      if (done_vld) begin
        o_done_cyc = c; o_is_load = done_is_load; o_rd = done_rd;
        o_data = done_data; o_mis = done_misalign;
      end else if (req_rdy) o_rdy_low = 0;
      if (mem_req_vld) begin
        if (o_req_cnt == 0) {o_addr, o_be, o_we, o_wdata} = {mem_req_addr, mem_req_be, mem_req_we, mem_req_wdata};
        else if ({mem_req_addr, mem_req_be, mem_req_we, mem_req_wdata} !== {o_addr, o_be, o_we, o_wdata}) o_stable = 0;
        o_req_cnt++;
        if (noise) mem_rsp_vld = 1'b1;
        if (rw == 0) begin mem_req_rdy = 1'b1; hs = 1; end
        else rw--;
      end else if (in_rsp) begin
        if (sw == 0) begin mem_rsp_vld = 1'b1; mem_rsp_rdata = rdata; in_rsp = 0; end
        else sw--;
      end else if (noise) mem_rsp_vld = 1'b1;
      @(posedge clk);
      if (hs) in_rsp = 1;
    end
    if (o_done_cyc < 0) o_timeout = 1;
    mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_rdy, mem_req_vld, done_vld, done_misalign, done_is_load} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/mreq/done/mis/ld=%b expected 00000",
               {req_rdy, mem_req_vld, done_vld, done_misalign, done_is_load});
    end
    checks++;
    if ({mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, done_rd, done_data} !== 106'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h we=%b be=%b wdata=%h rd=%0d data=%h expected all 0",
               mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, done_rd, done_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy_after: got %b expected 1", req_rdy);
    end
    @(negedge clk);
  endtask

  task automatic test_lw();
    do_txn(mk_load(3'b010, 5'd7, 12'd4), 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    checks++;
    if ({o_addr, o_be, o_we, o_req_cnt} !== {32'h1004, 4'b1111, 1'b0, 32'd1}) begin
      errors++; $display("FAIL lw_req: got addr=%h be=%b we=%b n=%0d expected 1004 1111 0 1", o_addr, o_be, o_we, o_req_cnt);
    end
    checks++;
    if ({o_done_cyc, o_is_load, o_rd, o_data} !== {32'd3, 1'b1, 5'd7, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL lw_done: got cyc=%0d ld=%b rd=%0d data=%h expected 3 1 7 deadbeef", o_done_cyc, o_is_load, o_rd, o_data);
    end
  endtask

  task automatic test_lb_lbu();
    do_txn(mk_load(3'b000, 5'd9, 12'd3), 32'h1000, 32'h0, 32'h80A5_5A01, 0, 0, 0);
    checks++;
    if ({o_addr, o_be, o_data} !== {32'h1000, 4'b1000, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL lb: got addr=%h be=%b data=%h expected 1000 1000 ffffff80", o_addr, o_be, o_data);
    end
    do_txn(mk_load(3'b100, 5'd9, 12'd3), 32'h1000, 32'h0, 32'h80A5_5A01, 0, 0, 0);
    checks++;
    if ({o_be, o_data} !== {4'b1000, 32'h0000_0080}) begin
      errors++; $display("FAIL lbu: got be=%b data=%h expected 1000 00000080", o_be, o_data);
    end
  endtask

  task automatic test_sb();
    do_txn(mk_store(3'b000, 12'd2), 32'h2000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0);
    checks++;
    if ({o_addr, o_be, o_we, o_wdata} !== {32'h2000, 4'b0100, 1'b1, 32'h7878_7878}) begin
      errors++; $display("FAIL sb_req: got addr=%h be=%b we=%b wdata=%h expected 2000 0100 1 78787878", o_addr, o_be, o_we, o_wdata);
    end
    checks++;
    if ({o_done_cyc, o_is_load, o_data} !== {32'd3, 1'b0, 32'h0}) begin
      errors++; $display("FAIL sb_done: got cyc=%0d ld=%b data=%h expected 3 0 0", o_done_cyc, o_is_load, o_data);
    end
  endtask

  task automatic test_backpressure();
    do_txn(mk_load(3'b010, 5'd2, 12'd8), 32'h3000, 32'h0, 32'h0BAD_F00D, 5, 0, 0);
    checks++;
    if ({o_stable, o_rdy_low, o_req_cnt} !== {1'b1, 1'b1, 32'd6}) begin
      errors++; $display("FAIL bp_hold: got stable=%b rdy_low=%b req_cycles=%0d expected 1 1 6", o_stable, o_rdy_low, o_req_cnt);
    end
    checks++;
    if ({o_done_cyc, o_data} !== {32'd8, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL bp_done: got cyc=%0d data=%h expected 8 0badf00d", o_done_cyc, o_data);
    end
  endtask

  task automatic test_misalign();
    do_txn(mk_load(3'b010, 5'd5, 12'd2), 32'h1000, 32'h0, 32'hCAFE_1234, 0, 0, 0);
`ifdef RV_LSU_MISALIGN_EXC_EN
    checks++;
    if ({o_req_cnt, o_mis, o_data, o_done_cyc} !== {32'd0, 1'b1, 32'h1002, 32'd1}) begin
      errors++; $display("FAIL misalign_exc: got req_cycles=%0d mis=%b data=%h cyc=%0d expected 0 1 1002 1", o_req_cnt, o_mis, o_data, o_done_cyc);
    end
`else
    checks++;
    if ({o_addr, o_be, o_mis, o_data, o_done_cyc} !== {32'h1000, 4'b1111, 1'b0, 32'hCAFE_1234, 32'd3}) begin
      errors++; $display("FAIL misalign_bus: got addr=%h be=%b mis=%b data=%h cyc=%0d expected 1000 1111 0 cafe1234 3", o_addr, o_be, o_mis, o_data, o_done_cyc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    req_vld = 1'b1; req_inst = mk_load(3'b010, 5'd4, 12'd0); req_rs1 = 32'h4000;
    @(posedge clk); @(negedge clk);
    req_vld = 1'b0; mem_req_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_req_rdy = 1'b0; mem_rsp_vld = 1'b1; mem_rsp_rdata = 32'h5555_AAAA; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_rsp_vld = 1'b0;
    checks++;
    if ({done_vld, req_rdy, mem_req_vld, done_data} !== 35'd0) begin
      errors++; $display("FAIL rstmid_in_reset: got done=%b rdy=%b mreq=%b data=%h expected 0 0 0 0", done_vld, req_rdy, mem_req_vld, done_data);
    end
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_vld || mem_req_vld || !req_rdy) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet: got activity=%b expected 0", seen);
    end
    do_txn(mk_load(3'b010, 5'd11, 12'd0), 32'h4000, 32'h0, 32'h1357_9BDF, 0, 0, 0);
    checks++;
    if ({o_done_cyc, o_rd, o_data} !== {32'd3, 5'd11, 32'h1357_9BDF}) begin
      errors++; $display("FAIL rstmid_next: got cyc=%0d rd=%0d data=%h expected 3 11 13579bdf", o_done_cyc, o_rd, o_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int w, rqw, rsw;
      bit ld, noise;
      logic [2:0] f3;
      logic [31:0] inst, rs1, rs2, rdata;
      ld = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 2);
      f3 = 3'(w);
      if (ld && w < 2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      inst  = ld ? mk_load(f3, 5'($urandom()), 12'($urandom())) : mk_store(f3, 12'($urandom()));
      rs1   = $urandom(); rs2 = $urandom(); rdata = $urandom();
      rqw   = $urandom_range(0, 3); rsw = $urandom_range(0, 3);
      noise = 1'($urandom_range(0, 1));
      do_txn(inst, rs1, rs2, rdata, rqw, rsw, noise);
      model(inst, rs1, rs2, rdata, rqw, rsw);
      checks++;
      if ({o_timeout, o_done_cyc} !== {1'b0, 32'(e_done_cyc)}) begin
        errors++; $display("FAIL rnd%0d_latency: got timeout=%b cyc=%0d expected 0 %0d", n, o_timeout, o_done_cyc, e_done_cyc);
      end
      checks++;
      if ({o_is_load, o_mis, o_data} !== {e_is_load, e_mis, e_data}) begin
        errors++; $display("FAIL rnd%0d_result: got ld=%b mis=%b data=%h expected %b %b %h", n, o_is_load, o_mis, o_data, e_is_load, e_mis, e_data);
      end
      if (e_is_load) begin
        checks++;
        if (o_rd !== e_rd) begin
          errors++; $display("FAIL rnd%0d_rd: got %0d expected %0d", n, o_rd, e_rd);
        end
      end
      checks++;
      if (o_req_cnt !== (e_bus ? rqw + 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_req_cycles: got %0d expected %0d", n, o_req_cnt, e_bus ? rqw + 1 : 0);
      end
      if (e_bus) begin
        checks++;
        if ({o_addr, o_be, o_we, o_wdata} !== {e_addr, e_be, e_we, e_wdata}) begin
          errors++; $display("FAIL rnd%0d_bus: got addr=%h be=%b we=%b wdata=%h expected %h %b %b %h", n, o_addr, o_be, o_we, o_wdata, e_addr, e_be, e_we, e_wdata);
        end
      end
      checks++;
      if ({o_after_vld, o_after_rdy, o_stable, o_rdy_low} !== 4'b0111) begin
        errors++; $display("FAIL rnd%0d_handshake: got after_done=%b after_rdy=%b stable=%b rdy_low=%b expected 0111", n, o_after_vld, o_after_rdy, o_stable, o_rdy_low);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sb();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
